cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The module SHALL have a clk input, 1 bit, as its only clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have a reset_n input, 1 bit, which is a synchronous, active-low reset.
REQ-003 The module SHALL have an s input, 1 bit, which starts execution of the held instruction while in Wait.
REQ-004 The module SHALL have a load input, 1 bit, which captures in into the instruction register (IR) on the clock edge.
REQ-005 The module SHALL have an in input, 16 bits, carrying the instruction word.
REQ-006 The module SHALL have a w output, 1 bit, high only in Wait.
REQ-007 The module SHALL have outputs write, loada, loadb, loadc, loads, asel and bsel, each 1 bit, which are the datapath strobes and selects.
REQ-008 The module SHALL have a vsel output, 2 bits: 00 selects datapath C, 10 selects sximm8; 01 and 11 are never driven.
REQ-009 The module SHALL have readnum and writenum outputs, 3 bits each, carrying register-file indices.
REQ-010 The module SHALL have a shift output, 2 bits, and an ALUop output, 2 bits.
REQ-011 The module SHALL have an sximm8 output, 16 bits, equal to IR[7:0] sign-extended.
REQ-012 The module SHALL have an sximm5 output, 16 bits, equal to IR[4:0] sign-extended.
REQ-013 The module SHALL have a trap output, 1 bit, present only when CPU_CTRL_TRAP_EN is defined.

Function
REQ-014 IR fields SHALL be decoded as: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-015 The IR SHALL load whenever load=1, in any state; a running instruction SHALL use the value the IR holds in each state (no shadow copy is kept).
REQ-016 The FSM states SHALL be Wait, Decode, GetA, GetB, Alu, WriteReg, WriteImm and Trap (Trap only with the macro); all outputs are Moore decodes of the state register plus IR fields.
REQ-017 From Wait, s=1 SHALL move to Decode on the next edge; s=0 SHALL hold Wait; s is ignored in all other states.
REQ-018 MOV Rn,#imm8 (110/10) SHALL follow Decode->WriteImm->Wait, with WriteImm driving write=1, vsel=10 and writenum=Rn.
REQ-019 MOV Rd,Rm{,sh} (110/00) SHALL follow Decode->GetB->Alu->WriteReg->Wait, with Alu driving asel=1, bsel=0, ALUop=00 and loadc=1.
REQ-020 ADD (101/00) and AND (101/10) SHALL follow Decode->GetA->GetB->Alu->WriteReg->Wait.
REQ-021 CMP (101/01) SHALL follow Decode->GetA->GetB->Alu->Wait, with Alu driving loads=1, loadc=0 and no write.
REQ-022 MVN (101/11) SHALL follow Decode->GetB->Alu->WriteReg->Wait.
REQ-023 In GetA the outputs SHALL be readnum=Rn, loada=1; in GetB, readnum=Rm, loadb=1.
REQ-024 In Alu the outputs SHALL be ALUop=op, shift=sh (00 for MOV-imm), asel=0 (except MOV-reg), bsel=0, and loadc=1 (except CMP).
REQ-025 In WriteReg the outputs SHALL be write=1, vsel=00, writenum=Rd.
REQ-026 Every strobe SHALL be high for exactly one cycle per state visit; all outputs not listed for a state SHALL be 0.
REQ-027 Any opcode/op combination not listed SHALL be treated as illegal (see Configuration).

Reset
REQ-028 reset_n=0 at an edge SHALL force Wait and IR=0 from any state, including mid-instruction; no write is issued in the cycle following reset.
REQ-029 After reset the outputs SHALL be: w=1, trap=0, all strobes 0, vsel=00, readnum=writenum=0, shift=ALUop=00.
REQ-030 Reset SHALL take priority over load and s in the same cycle.

Configuration
REQ-031 With CPU_CTRL_TRAP_EN defined, an illegal instruction SHALL go Decode->Trap; Trap holds trap=1, w=0 and all strobes 0, and is left only by reset.
REQ-032 With CPU_CTRL_TRAP_EN undefined, an illegal instruction SHALL go Decode->Wait (a 2-cycle NOP), and the trap port SHALL be absent.

Structure
REQ-033 A shared package cpu_pkg SHALL hold the state enum, opcode/op constants, vsel encodings (VSEL_C=00, VSEL_IMM8=10) and the ALUop encodings.
REQ-034 Combinational field extraction, sign-extension and legality SHALL be in a sub-module ir_decoder; cpu_ctrl holds the IR and the FSM.

Verification
REQ-035 Reset scenario: reset_n=0 for one cycle in the middle of ADD -> next cycle w=1, write=0, loadc=0.
REQ-036 MOV-imm scenario: load in=0xD180 (MOV R1,#-128), then s=1 -> WriteImm shows write=1, vsel=10, writenum=1, sximm8=0xFF80; w=1 two cycles after Decode.
REQ-037 ADD scenario: in=0xA140 (ADD R2,R1,R0) -> GetA readnum=1/loada; GetB readnum=0/loadb; Alu ALUop=00/loadc; WriteReg writenum=2/write; w returns after 6 edges from s.
REQ-038 MOV-reg scenario: in=0xC06D (MOV R3,R5,LSL#1) -> GetB readnum=5; Alu asel=1, shift=01; WriteReg writenum=3.
REQ-039 CMP scenario: in=0xA900 (CMP R1,R0) -> Alu loads=1, loadc=0, ALUop=01; no write observed before w=1.
REQ-040 Illegal scenario: in=0x0000 with s=1 -> with the macro, trap=1 holds for 10+ cycles until reset; without it, w=1 two edges after s.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the cpu_ctrl controller and its instruction decoder.
// The Trap state and trap output bit exist only when CPU_CTRL_TRAP_EN is defined.
package cpu_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_GETA     = 3'd2,
    ST_GETB     = 3'd3,
    ST_ALU      = 3'd4,
    ST_WRITEREG = 3'd5,
    ST_WRITEIMM = 3'd6
`ifdef CPU_CTRL_TRAP_EN
    ,ST_TRAP    = 3'd7
`endif
  } state_e;

  typedef enum logic [2:0] {
    INST_ILLEGAL = 3'd0,
    INST_MOV_IMM = 3'd1,
    INST_MOV_REG = 3'd2,
    INST_ADD     = 3'd3,
    INST_CMP     = 3'd4,
    INST_AND     = 3'd5,
    INST_MVN     = 3'd6
  } inst_e;

  typedef struct packed {
    logic       w;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] shift;
    logic [1:0] alu_op;
`ifdef CPU_CTRL_TRAP_EN
    logic       trap;
`endif
  } ctrl_out_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  // Moore output decode: a state plus the fields of the IR held in that state.
  function automatic ctrl_out_t decode_outputs(
    input state_e     st,
    input inst_e      cls,
    input logic [1:0] op,
    input logic [1:0] sh,
    input logic [2:0] rn,
    input logic [2:0] rd,
    input logic [2:0] rm
  );
    ctrl_out_t o;
    o = '0;
    case (st)
      ST_WAIT: begin
        o.w = 1'b1;
      end
      ST_DECODE: begin
        o.w = 1'b0;
      end
      ST_GETA: begin
        o.readnum = rn;
        o.loada   = 1'b1;
      end
      ST_GETB: begin
        o.readnum = rm;
        o.loadb   = 1'b1;
      end
      ST_ALU: begin
        o.alu_op = op;
        o.shift  = (cls == INST_MOV_IMM) ? 2'b00 : sh;
        o.asel   = (cls == INST_MOV_REG);
        o.bsel   = 1'b0;
        o.loadc  = (cls != INST_CMP);
        o.loads  = (cls == INST_CMP);
      end
      ST_WRITEREG: begin
        o.write    = 1'b1;
        o.vsel     = VSEL_C;
        o.writenum = rd;
      end
      ST_WRITEIMM: begin
        o.write    = 1'b1;
        o.vsel     = VSEL_IMM8;
        o.writenum = rn;
      end
`ifdef CPU_CTRL_TRAP_EN
      ST_TRAP: begin
        o.trap = 1'b1;
      end
`endif
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ir_decoder.sv
// Purely combinational instruction field extraction, sign-extension and
// instruction classification (illegal encodings map to INST_ILLEGAL).
module ir_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output inst_e       cls
);

  logic [2:0] w_opcode;

  assign w_opcode = ir[15:13];
  assign op       = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign sh       = ir[4:3];
  assign rm       = ir[2:0];
  assign sximm8   = sext8(ir[7:0]);
  assign sximm5   = sext5(ir[4:0]);

  // Classify the opcode/op pair; anything unlisted is illegal.
  always_comb begin
    cls = INST_ILLEGAL;
    case (w_opcode)
      OPC_MOV: begin
        case (op)
          OP_MOV_IMM: cls = INST_MOV_IMM;
          OP_MOV_REG: cls = INST_MOV_REG;
          default:    cls = INST_ILLEGAL;
        endcase
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = INST_ADD;
          OP_CMP:  cls = INST_CMP;
          OP_AND:  cls = INST_AND;
          OP_MVN:  cls = INST_MVN;
          default: cls = INST_ILLEGAL;
        endcase
      end
      default: cls = INST_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register plus multi-cycle control FSM for a simple 16-bit datapath.
// Define CPU_CTRL_TRAP_EN to trap on illegal instructions (adds the trap port).
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
`ifdef CPU_CTRL_TRAP_EN
  ,output logic       trap
`endif
);

  logic [15:0] r_ir;
  inst_e       r_cls;
  state_e      r_state;
  ctrl_out_t   r_out;
  logic [15:0] r_sximm8;
  logic [15:0] r_sximm5;

  logic [15:0] w_ir_next;
  state_e      w_state_next;
  ctrl_out_t   w_out_next;
  logic [1:0]  w_op_next;
  logic [2:0]  w_rn_next;
  logic [2:0]  w_rd_next;
  logic [1:0]  w_sh_next;
  logic [2:0]  w_rm_next;
  logic [15:0] w_sximm8_next;
  logic [15:0] w_sximm5_next;
  inst_e       w_cls_next;

  assign w_ir_next = load ? in : r_ir;

  // Decoding the IR value that will be held next cycle lets every output be
  // registered while still matching a Moore decode of state plus current IR.
  ir_decoder u_ir_decoder (
    .ir     (w_ir_next),
    .op     (w_op_next),
    .rn     (w_rn_next),
    .rd     (w_rd_next),
    .sh     (w_sh_next),
    .rm     (w_rm_next),
    .sximm8 (w_sximm8_next),
    .sximm5 (w_sximm5_next),
    .cls    (w_cls_next)
  );

  // Next-state selection; branches use the class of the IR held this cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT: begin
        if (s) begin
          w_state_next = ST_DECODE;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_DECODE: begin
        case (r_cls)
          INST_MOV_IMM: w_state_next = ST_WRITEIMM;
          INST_MOV_REG: w_state_next = ST_GETB;
          INST_MVN:     w_state_next = ST_GETB;
          INST_ADD:     w_state_next = ST_GETA;
          INST_AND:     w_state_next = ST_GETA;
          INST_CMP:     w_state_next = ST_GETA;
`ifdef CPU_CTRL_TRAP_EN
          default:      w_state_next = ST_TRAP;
`else
          default:      w_state_next = ST_WAIT;
`endif
        endcase
      end
      ST_GETA:     w_state_next = ST_GETB;
      ST_GETB:     w_state_next = ST_ALU;
      ST_ALU: begin
        if (r_cls == INST_CMP) begin
          w_state_next = ST_WAIT;
        end else begin
          w_state_next = ST_WRITEREG;
        end
      end
      ST_WRITEREG: w_state_next = ST_WAIT;
      ST_WRITEIMM: w_state_next = ST_WAIT;
`ifdef CPU_CTRL_TRAP_EN
      ST_TRAP:     w_state_next = ST_TRAP;
`endif
      default:     w_state_next = ST_WAIT;
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    w_out_next = decode_outputs(w_state_next, w_cls_next, w_op_next, w_sh_next,
                                w_rn_next, w_rd_next, w_rm_next);
  end

  // State, IR and registered outputs; reset wins over load and s.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_WAIT;
      r_ir     <= 16'h0000;
      r_cls    <= INST_ILLEGAL;
      r_sximm8 <= 16'h0000;
      r_sximm5 <= 16'h0000;
      r_out    <= decode_outputs(ST_WAIT, INST_ILLEGAL, 2'b00, 2'b00,
                                 3'b000, 3'b000, 3'b000);
    end else begin
      r_state  <= w_state_next;
      r_ir     <= w_ir_next;
      r_cls    <= w_cls_next;
      r_sximm8 <= w_sximm8_next;
      r_sximm5 <= w_sximm5_next;
      r_out    <= w_out_next;
    end
  end

  assign w        = r_out.w;
  assign write    = r_out.write;
  assign loada    = r_out.loada;
  assign loadb    = r_out.loadb;
  assign loadc    = r_out.loadc;
  assign loads    = r_out.loads;
  assign asel     = r_out.asel;
  assign bsel     = r_out.bsel;
  assign vsel     = r_out.vsel;
  assign readnum  = r_out.readnum;
  assign writenum = r_out.writenum;
  assign shift    = r_out.shift;
  assign ALUop    = r_out.alu_op;
  assign sximm8   = r_sximm8;
  assign sximm5   = r_sximm5;
`ifdef CPU_CTRL_TRAP_EN
  assign trap     = r_out.trap;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: an instruction-level model expands each started
// instruction into its expected per-cycle outputs, checked every cycle.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic        load;
  logic [15:0] in_s;
  logic        w_o, write_o, loada_o, loadb_o, loadc_o, loads_o, asel_o, bsel_o;
  logic [1:0]  vsel_o, shift_o, aluop_o;
  logic [2:0]  readnum_o, writenum_o;
  logic [15:0] sximm8_o, sximm5_o;
`ifdef CPU_CTRL_TRAP_EN
  logic        trap_o;
`endif

  cpu_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in_s),
    .w(w_o), .write(write_o), .loada(loada_o), .loadb(loadb_o), .loadc(loadc_o),
    .loads(loads_o), .asel(asel_o), .bsel(bsel_o), .vsel(vsel_o),
    .readnum(readnum_o), .writenum(writenum_o), .shift(shift_o), .ALUop(aluop_o),
    .sximm8(sximm8_o), .sximm5(sximm5_o)
`ifdef CPU_CTRL_TRAP_EN
    ,.trap(trap_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic [2:0] readnum, writenum;
    logic [1:0] shift, aluop;
    logic       trap;
  } obs_t;

  obs_t        q[$];
  logic [15:0] m_ir;
  bit          m_valid = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
    int x;
    x = int'(v) & ((1 << bits) - 1);
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return x[15:0];
  endfunction

  // Expand one instruction into the outputs of each cycle after it leaves Wait.
  task automatic push_instr(input logic [15:0] ir);
    logic [2:0] opc;
    logic [1:0] op;
    obs_t o;
    opc = ir[15:13];
    op  = ir[12:11];
    q.push_back(obs_t'(0));
    if (opc == 3'd6 && op == 2'd2) begin
      o = '0; o.write = 1'b1; o.vsel = 2'b10; o.writenum = ir[10:8]; q.push_back(o);
    end else if ((opc == 3'd6 && op == 2'd0) || opc == 3'd5) begin
      if (opc == 3'd5 && op != 2'd3) begin
        o = '0; o.readnum = ir[10:8]; o.loada = 1'b1; q.push_back(o);
      end
      o = '0; o.readnum = ir[2:0]; o.loadb = 1'b1; q.push_back(o);
      o = '0; o.aluop = op; o.shift = ir[4:3]; o.asel = (opc == 3'd6);
      o.loads = (opc == 3'd5 && op == 2'd1); o.loadc = !o.loads; q.push_back(o);
      if (!(opc == 3'd5 && op == 2'd1)) begin
        o = '0; o.write = 1'b1; o.writenum = ir[7:5]; q.push_back(o);
      end
    end else begin
`ifdef CPU_CTRL_TRAP_EN
      o = '0; o.trap = 1'b1; q.push_back(o);
`endif
    end
  endtask

  // Model advance on each rising edge.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_ir = 16'h0000;
      m_valid = 1'b1;
    end else begin
      if (q.size() > 0) begin
        if (!q[0].trap) void'(q.pop_front());
      end else if (s) begin
        push_instr(m_ir);
      end
      if (load) m_ir = in_s;
    end
  end

  obs_t dut_obs;
  always_comb begin
    dut_obs = '0;
    dut_obs.w = w_o; dut_obs.write = write_o; dut_obs.loada = loada_o;
    dut_obs.loadb = loadb_o; dut_obs.loadc = loadc_o; dut_obs.loads = loads_o;
    dut_obs.asel = asel_o; dut_obs.bsel = bsel_o; dut_obs.vsel = vsel_o;
    dut_obs.readnum = readnum_o; dut_obs.writenum = writenum_o;
    dut_obs.shift = shift_o; dut_obs.aluop = aluop_o;
`ifdef CPU_CTRL_TRAP_EN
    dut_obs.trap = trap_o;
`endif
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    obs_t e;
    @(negedge clk);
    if (m_valid) begin
      e = '0;
      if (q.size() > 0) e = q[0];
      else e.w = 1'b1;
      chk("outputs", 32'(dut_obs), 32'(e));
      chk("sximm8", 32'(sximm8_o), 32'(sext(m_ir, 8)));
      chk("sximm5", 32'(sximm5_o), 32'(sext(m_ir, 5)));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ir(input logic [15:0] v);
    load = 1'b1; in_s = v; step(); load = 1'b0;
  endtask

  task automatic start();
    s = 1'b1; step(); s = 1'b0;
  endtask

  task automatic run_to_wait(input logic [15:0] v);
    load_ir(v); start();
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; s = 1'b0; load = 1'b0; in_s = 16'h0000;
    step(); step();
    chk("reset_w", 32'(w_o), 32'd1);
    chk("reset_write", 32'(write_o), 32'd0);
    reset_n = 1'b1;

    // MOV R1,#-128
    load_ir(16'hD180); start();
    chk("movi_decode_w", 32'(w_o), 32'd0);
    step();
    chk("movi_write", 32'(write_o), 32'd1);
    chk("movi_vsel", 32'(vsel_o), 32'd2);
    chk("movi_writenum", 32'(writenum_o), 32'd1);
    chk("movi_sximm8", 32'(sximm8_o), 32'h0000FF80);
    step();
    chk("movi_w_back", 32'(w_o), 32'd1);

    // ADD R2,R1,R0
    load_ir(16'hA140); start(); step();
    chk("add_geta_readnum", 32'(readnum_o), 32'd1);
    chk("add_geta_loada", 32'(loada_o), 32'd1);
    step();
    chk("add_getb_readnum", 32'(readnum_o), 32'd0);
    chk("add_getb_loadb", 32'(loadb_o), 32'd1);
    step();
    chk("add_alu_op", 32'(aluop_o), 32'd0);
    chk("add_alu_loadc", 32'(loadc_o), 32'd1);
    step();
    chk("add_wr_writenum", 32'(writenum_o), 32'd2);
    chk("add_wr_write", 32'(write_o), 32'd1);
    step();
    chk("add_w_back", 32'(w_o), 32'd1);

    // MOV R3,R5,LSL#1
    load_ir(16'hC06D); start(); step();
    chk("movr_getb_readnum", 32'(readnum_o), 32'd5);
    step();
    chk("movr_alu_asel", 32'(asel_o), 32'd1);
    chk("movr_alu_shift", 32'(shift_o), 32'd1);
    step();
    chk("movr_wr_writenum", 32'(writenum_o), 32'd3);
    step();

    // CMP R1,R0
    load_ir(16'hA900); start(); step(); step(); step();
    chk("cmp_alu_loads", 32'(loads_o), 32'd1);
    chk("cmp_alu_loadc", 32'(loadc_o), 32'd0);
    chk("cmp_alu_op", 32'(aluop_o), 32'd1);
    step();
    chk("cmp_w_back", 32'(w_o), 32'd1);

    // MVN R7,R2 and AND R5,R2,R0{LSL#1}, then negative sximm5 values
    run_to_wait(16'hB8E2);
    run_to_wait(16'hB2A8);
    load_ir(16'h001F);
    chk("sximm5_neg", 32'(sximm5_o), 32'h0000FFFF);
    load_ir(16'h0010);

    // Reset in the middle of ADD, asserted together with load and s
    load_ir(16'hA140); start(); step(); step();
    reset_n = 1'b0; load = 1'b1; in_s = 16'hD180; s = 1'b1;
    step();
    reset_n = 1'b1; load = 1'b0; s = 1'b0;
    chk("rst_mid_w", 32'(w_o), 32'd1);
    chk("rst_mid_write", 32'(write_o), 32'd0);
    chk("rst_mid_loadc", 32'(loadc_o), 32'd0);
    chk("rst_mid_sximm8", 32'(sximm8_o), 32'd0);
    step();

    // Illegal instruction 0x0000
    start();
`ifdef CPU_CTRL_TRAP_EN
    for (int i = 0; i < 12; i++) begin
      step();
      chk("trap_hold", 32'(trap_o), 32'd1);
    end
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("trap_cleared", 32'(trap_o), 32'd0);
`else
    step();
    chk("illegal_w_back", 32'(w_o), 32'd1);
`endif
    step();
    run_to_wait(16'hC800);
`ifdef CPU_CTRL_TRAP_EN
    reset_n = 1'b0; step(); reset_n = 1'b1;
`endif
    run_to_wait(16'hE000);
`ifdef CPU_CTRL_TRAP_EN
    reset_n = 1'b0; step(); reset_n = 1'b1;
`endif
    run_to_wait(16'hD27F);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
